// File: rtl/esc_pwm_pkg.sv
// Shared types, default parameter values and helpers for the multi-channel ESC PWM generator.
package esc_pwm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2
    } esc_state_t;

    localparam int unsigned DEF_CHANNELS       = 2;
    localparam int unsigned DEF_CMD_W          = 10;
    localparam int unsigned DEF_FRAME_TICKS    = 1_000_000;
    localparam int unsigned DEF_MIN_TICKS      = 50_000;
    localparam int unsigned DEF_MAX_TICKS      = 100_000;
    localparam int unsigned DEF_SLEW_STEP      = 8;
    localparam int unsigned DEF_ARM_FRAMES     = 50;
    localparam int unsigned DEF_TIMEOUT_FRAMES = 25;

    // Register width able to hold the values 0..n-1 (never less than one bit).
    function automatic int bits_for(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Command to pulse width; the 64-bit product keeps every bit until the shift.
    function automatic logic [63:0] map_width(input logic [31:0] applied,
                                              input int unsigned min_t,
                                              input int unsigned max_t,
                                              input int unsigned cmd_w);
        logic [63:0] prod;
        prod = 64'(applied) * 64'(max_t - min_t);
        return 64'(min_t) + (prod >> cmd_w);
    endfunction

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output: command target, slew-limited applied value, watchdog and pulse comparator.
module esc_pwm_channel
    import esc_pwm_pkg::*;
#(
    parameter int unsigned CMD_W          = DEF_CMD_W,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned MIN_TICKS      = DEF_MIN_TICKS,
    parameter int unsigned MAX_TICKS      = DEF_MAX_TICKS,
    parameter int unsigned SLEW_STEP      = DEF_SLEW_STEP,
    parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input  logic             c50m,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             pwm_en,
    input  logic             frame_tick,
    input  logic [CNT_W-1:0] count,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_valid,
    output logic             pwm_out,
    output logic             fault_timeout
);

    localparam int WD_W = bits_for(TIMEOUT_FRAMES + 1);
    localparam logic [CMD_W-1:0] STEP = CMD_W'(SLEW_STEP);

    logic [CMD_W-1:0] target_reg;
    logic [CMD_W-1:0] applied_reg;
    logic [CMD_W-1:0] applied_next;
    logic [CMD_W-1:0] slew_val;
    logic [WD_W-1:0]  wd_reg;
    logic [CNT_W-1:0] width_reg;
    logic             fault_reg;
    logic             wd_expire;

    // A full step is taken only when the gap exceeds it, so the result never passes the target.
    always_comb begin
        slew_val = applied_reg;
        if (target_reg >= applied_reg) begin
            if ((target_reg - applied_reg) <= STEP) slew_val = target_reg;
            else                                    slew_val = applied_reg + STEP;
        end else begin
            if ((applied_reg - target_reg) <= STEP) slew_val = target_reg;
            else                                    slew_val = applied_reg - STEP;
        end
    end

    always_comb begin
        applied_next = applied_reg;
        if (clear || !run) applied_next = '0;
        else if (frame_tick) applied_next = slew_val;
    end

    assign wd_expire = run && frame_tick && !cmd_valid && (wd_reg == WD_W'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            target_reg  <= '0;
            applied_reg <= '0;
            wd_reg      <= '0;
            fault_reg   <= 1'b0;
            width_reg   <= '0;
        end else begin
            applied_reg <= applied_next;
            if (frame_tick) begin
                width_reg <= CNT_W'(map_width(32'(applied_next), MIN_TICKS, MAX_TICKS, CMD_W));
            end
            if (clear) begin
                target_reg <= '0;
                fault_reg  <= 1'b0;
                wd_reg     <= '0;
            end else begin
                if (cmd_valid) begin
                    target_reg <= cmd;
                    fault_reg  <= 1'b0;
                end else if (wd_expire) begin
                    target_reg <= '0;
                    fault_reg  <= 1'b1;
                end
                if (!run || cmd_valid) wd_reg <= '0;
                else if (frame_tick && (wd_reg != WD_W'(TIMEOUT_FRAMES))) wd_reg <= wd_reg + WD_W'(1);
            end
        end
    end

    assign pwm_out       = pwm_en && (count < width_reg);
    assign fault_timeout = fault_reg;

endmodule

// File: rtl/esc_pwm_multi.sv
// Multi-channel servo-style ESC pulse generator with arming sequence, slew limiting and watchdog.
module esc_pwm_multi
    import esc_pwm_pkg::*;
#(
    parameter int unsigned CHANNELS       = DEF_CHANNELS,
    parameter int unsigned CMD_W          = DEF_CMD_W,
    parameter int unsigned FRAME_TICKS    = DEF_FRAME_TICKS,
    parameter int unsigned MIN_TICKS      = DEF_MIN_TICKS,
    parameter int unsigned MAX_TICKS      = DEF_MAX_TICKS,
    parameter int unsigned SLEW_STEP      = DEF_SLEW_STEP,
    parameter int unsigned ARM_FRAMES     = DEF_ARM_FRAMES,
    parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
    input  logic                      c50m,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*CMD_W-1:0] cmd,
    input  logic [CHANNELS-1:0]       cmd_valid,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      armed,
    output logic [CHANNELS-1:0]       fault_timeout,
    output logic                      frame_tick
);

    localparam int CNT_W = bits_for(FRAME_TICKS);
    localparam int ARM_W = bits_for(ARM_FRAMES + 1);

    esc_state_t       state_reg;
    esc_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [ARM_W-1:0] arm_reg;
    logic             run;
    logic             pwm_en;

    assign frame_tick = (count_reg == CNT_W'(FRAME_TICKS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DISARMED: if (frame_tick) state_next = ARMING;
            ARMING:   if (frame_tick && (arm_reg == ARM_W'(ARM_FRAMES - 1))) state_next = RUN;
            RUN:      state_next = RUN;
            default:  state_next = DISARMED;
        endcase
        // Dropping enable overrides every other transition.
        if (!enable) state_next = DISARMED;
    end

    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            state_reg <= DISARMED;
            count_reg <= '0;
            arm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= frame_tick ? '0 : count_reg + CNT_W'(1);
            if (state_reg != ARMING) arm_reg <= '0;
            else if (frame_tick)     arm_reg <= arm_reg + ARM_W'(1);
        end
    end

    assign run    = (state_reg == RUN);
    assign pwm_en = (state_reg == ARMING) || (state_reg == RUN);
    assign armed  = run;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        esc_pwm_channel #(
            .CMD_W          (CMD_W),
            .CNT_W          (CNT_W),
            .MIN_TICKS      (MIN_TICKS),
            .MAX_TICKS      (MAX_TICKS),
            .SLEW_STEP      (SLEW_STEP),
            .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
        ) u_ch (
            .c50m          (c50m),
            .reset         (reset),
            .clear         (!enable),
            .run           (run),
            .pwm_en        (pwm_en),
            .frame_tick    (frame_tick),
            .count         (count_reg),
            .cmd           (cmd[gi*CMD_W +: CMD_W]),
            .cmd_valid     (cmd_valid[gi]),
            .pwm_out       (pwm_out[gi]),
            .fault_timeout (fault_timeout[gi])
        );
    end

endmodule
